// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and PC-select constants shared by the pipeline control unit
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, ENTER, HALT} state_e;
  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_INT = 2'd2;
  localparam int DRAIN_CYCLES_DEF = 3;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in ID/EX whose destination is read by the instruction in IF/ID
module load_use_detect (
  input  logic       memread_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       use_rs_i,
  input  logic       use_rt_i,
  output logic       hazard_o
);
  assign hazard_o = memread_i && rd_i != 5'd0 &&
                    ((use_rs_i && rs_i == rd_i) || (use_rt_i && rt_i == rd_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage enables/bubbles, PC select, interrupt drain/entry, halt and stall/flush statistics
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             in_CLK,
  input  logic             in_CLR_n,
  input  logic             in_idex_memread,
  input  logic [4:0]       in_idex_rd,
  input  logic [4:0]       in_ifid_rs,
  input  logic [4:0]       in_ifid_rt,
  input  logic             in_ifid_use_rs,
  input  logic             in_ifid_use_rt,
  input  logic             in_branch_taken,
  input  logic             in_irq,
  input  logic             in_ie,
  input  logic             in_eret,
  input  logic             in_halt,
  output logic             out_pc_en,
  output logic             out_ifid_en,
  output logic             out_idex_en,
  output logic             out_exmem_en,
  output logic             out_memwb_en,
  output logic             out_ifid_bub,
  output logic             out_idex_bub,
  output logic             out_exmem_bub,
  output logic             out_memwb_bub,
  output logic [1:0]       out_pc_sel,
  output logic             out_int_ack,
  output logic             out_in_service,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_stall_cnt,
  output logic [CNT_W-1:0] out_flush_cnt
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             svc_q, svc_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu, stall_inc, flush_inc;
  logic             pc_en, ifid_en, low_en, ifid_bub, idex_bub, int_ack;
  logic [1:0]       pc_sel;

  load_use_detect u_lu (
    .memread_i (in_idex_memread),
    .rd_i      (in_idex_rd),
    .rs_i      (in_ifid_rs),
    .rt_i      (in_ifid_rt),
    .use_rs_i  (in_ifid_use_rs),
    .use_rt_i  (in_ifid_use_rt),
    .hazard_o  (lu)
  );

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    low_en    = 1'b1;
    ifid_bub  = 1'b0;
    idex_bub  = 1'b0;
    pc_sel    = PC_SEL_SEQ;
    int_ack   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (in_halt) begin
          state_d = HALT;
        end else if (in_branch_taken) begin
          pc_sel    = PC_SEL_BR;
          ifid_bub  = 1'b1;
          idex_bub  = 1'b1;
          flush_inc = 1'b1;
        end else begin
          if (lu) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_bub  = 1'b1;
            stall_inc = 1'b1;
          end
          if (in_irq && in_ie && !svc_q) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      DRAIN: begin
        pc_en    = 1'b0;
        ifid_bub = 1'b1;
        if (in_halt) begin
          state_d = HALT;
        end else if (in_branch_taken) begin
          pc_en     = 1'b1;
          pc_sel    = PC_SEL_BR;
          idex_bub  = 1'b1;
          flush_inc = 1'b1;
          state_d   = RUN;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
          if (dcnt_q == DW'(DRAIN_CYCLES - 1)) state_d = ENTER;
        end
      end
      ENTER: begin
        pc_sel   = PC_SEL_INT;
        int_ack  = 1'b1;
        ifid_bub = 1'b1;
        state_d  = RUN;
      end
      default: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        low_en  = 1'b0;
      end
    endcase
  end

  // entry sets in_service even if an ERET retires in the same cycle
  assign svc_d = (state_q == ENTER) || (svc_q && !(in_eret && state_q != HALT));

  always_ff @(posedge in_CLK or negedge in_CLR_n) begin
    if (!in_CLR_n) begin
      state_q <= RUN;
      dcnt_q  <= '0;
      svc_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      svc_q   <= svc_d;
      stall_q <= stall_q + CNT_W'(stall_inc && !(&stall_q));
      flush_q <= flush_q + CNT_W'(flush_inc && !(&flush_q));
    end
  end

  // reset forces enables off and all bubbles on without waiting for a clock
  assign out_pc_en      = in_CLR_n && pc_en;
  assign out_ifid_en    = in_CLR_n && ifid_en;
  assign out_idex_en    = in_CLR_n && low_en;
  assign out_exmem_en   = in_CLR_n && low_en;
  assign out_memwb_en   = in_CLR_n && low_en;
  assign out_ifid_bub   = !in_CLR_n || ifid_bub;
  assign out_idex_bub   = !in_CLR_n || idex_bub;
  assign out_exmem_bub  = !in_CLR_n;
  assign out_memwb_bub  = !in_CLR_n;
  assign out_pc_sel     = in_CLR_n ? pc_sel : PC_SEL_SEQ;
  assign out_int_ack    = in_CLR_n && int_ack;
  assign out_in_service = svc_q;
  assign out_halted     = in_CLR_n && state_q == HALT;
  assign out_stall_cnt  = stall_q;
  assign out_flush_cnt  = flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
  localparam int D    = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       memread = 0, use_rs = 0, use_rt = 0, br = 0, irq = 0, ie = 0, eret = 0, halt = 0;
  logic [4:0] rd = 0, rs = 0, rt = 0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_bub, idex_bub, exmem_bub, memwb_bub, int_ack, in_service, halted;
  logic [1:0] pc_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int compared = 0, mismatched = 0;
  bit m_halt = 0, m_enter = 0, m_svc = 0;
  int m_drain = -1, m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
    .in_CLK(clk), .in_CLR_n(rst_n),
    .in_idex_memread(memread), .in_idex_rd(rd),
    .in_ifid_rs(rs), .in_ifid_rt(rt), .in_ifid_use_rs(use_rs), .in_ifid_use_rt(use_rt),
    .in_branch_taken(br), .in_irq(irq), .in_ie(ie), .in_eret(eret), .in_halt(halt),
    .out_pc_en(pc_en), .out_ifid_en(ifid_en), .out_idex_en(idex_en),
    .out_exmem_en(exmem_en), .out_memwb_en(memwb_en),
    .out_ifid_bub(ifid_bub), .out_idex_bub(idex_bub),
    .out_exmem_bub(exmem_bub), .out_memwb_bub(memwb_bub),
    .out_pc_sel(pc_sel), .out_int_ack(int_ack), .out_in_service(in_service),
    .out_halted(halted), .out_stall_cnt(stall_cnt), .out_flush_cnt(flush_cnt)
  );

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit load_use();
    return memread && rd != 0 && ((use_rs && rs == rd) || (use_rt && rt == rd));
  endfunction

  function automatic int sat_inc(int v);
    return v < CMAX ? v + 1 : CMAX;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_enter = 0; m_svc = 0; m_drain = -1; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_outputs();
    bit e_pc = 1, e_ifid = 1, e_rest = 1, e_fb = 0, e_db = 0, e_lb = 0, e_ack = 0, e_h = 0;
    int e_sel = 0;
    if (!rst_n) begin
      e_pc = 0; e_ifid = 0; e_rest = 0; e_fb = 1; e_db = 1; e_lb = 1;
    end else if (m_halt) begin
      e_pc = 0; e_ifid = 0; e_rest = 0; e_h = 1;
    end else if (m_enter) begin
      e_sel = 2; e_ack = 1; e_fb = 1;
    end else if (m_drain >= 0) begin
      e_pc = 0; e_fb = 1;
      if (!halt && br) begin e_pc = 1; e_sel = 1; e_db = 1; end
    end else if (!halt) begin
      if (br) begin e_sel = 1; e_fb = 1; e_db = 1; end
      else if (load_use()) begin e_pc = 0; e_ifid = 0; e_db = 1; end
    end
    chk("pc_en", pc_en, e_pc);
    chk("ifid_en", ifid_en, e_ifid);
    chk("idex_en", idex_en, e_rest);
    chk("exmem_en", exmem_en, e_rest);
    chk("memwb_en", memwb_en, e_rest);
    chk("ifid_bub", ifid_bub, e_fb);
    chk("idex_bub", idex_bub, e_db);
    chk("exmem_bub", exmem_bub, e_lb);
    chk("memwb_bub", memwb_bub, e_lb);
    chk("pc_sel", pc_sel, e_sel);
    chk("int_ack", int_ack, e_ack);
    chk("halted", halted, e_h);
    chk("in_service", in_service, m_svc);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  task automatic model_edge();
    bit nsvc = m_enter ? 1'b1 : (eret && !m_halt) ? 1'b0 : m_svc;
    if (!rst_n) begin model_reset(); return; end
    if (m_halt) begin
    end else if (m_enter) begin
      m_enter = 0;
    end else if (m_drain >= 0) begin
      if (halt) begin m_halt = 1; m_drain = -1; end
      else if (br) begin m_flush = sat_inc(m_flush); m_drain = -1; end
      else begin
        m_drain++;
        if (m_drain == D) begin m_drain = -1; m_enter = 1; end
      end
    end else if (halt) begin
      m_halt = 1;
    end else if (br) begin
      m_flush = sat_inc(m_flush);
    end else begin
      if (load_use()) m_stall = sat_inc(m_stall);
      if (irq && ie && !m_svc) m_drain = 0;
    end
    m_svc = nsvc;
  endtask

  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    memread = 0; rd = 0; rs = 0; rt = 0; use_rs = 0; use_rt = 0;
    br = 0; irq = 0; ie = 0; eret = 0; halt = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    step();
    step();
    rst_n = 1;
    step();
    // load-use stall for exactly one cycle
    memread = 1; rd = 5; rs = 5; use_rs = 1;
    step();
    idle();
    step();
    chk("stall_cnt_one", stall_cnt, 1);
    memread = 1; rd = 0; rs = 0; use_rs = 1;
    step();
    idle();
    // branch outranks load-use
    do_reset();
    memread = 1; rd = 7; rt = 7; use_rt = 1; br = 1;
    step();
    idle();
    chk("flush_after_br", flush_cnt, 1);
    chk("stall_after_br", stall_cnt, 0);
    // interrupt entry, masking while in service, eret/irq collision
    do_reset();
    for (int i = 0; i < 3; i++) step();
    irq = 1; ie = 1;
    step();
    irq = 0;
    for (int i = 0; i < 5; i++) step();
    chk("svc_set", in_service, 1);
    irq = 1;
    step();
    step();
    eret = 1;
    step();
    eret = 0;
    step();
    irq = 0;
    for (int i = 0; i < 5; i++) step();
    // branch aborts drain, held irq restarts it
    do_reset();
    irq = 1; ie = 1;
    step();
    step();
    br = 1;
    step();
    br = 0;
    chk("flush_drain_abort", flush_cnt, 1);
    for (int i = 0; i < 6; i++) step();
    idle();
    // reset mid-drain gives no int_ack
    irq = 1; ie = 1; eret = 1;
    step();
    step();
    step();
    do_reset();
    idle();
    step();
    // halt is sticky until reset
    halt = 1;
    step();
    halt = 0;
    chk("halted_set", halted, 1);
    irq = 1; ie = 1; br = 1;
    for (int i = 0; i < 3; i++) step();
    chk("halted_hold", halted, 1);
    do_reset();
    idle();
    chk("halted_clr", halted, 0);
    step();
    // random traffic, small counters reach saturation
    for (int n = 0; n < 600; n++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) do_reset();
      memread = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom_range(0, 1));
      use_rt = 1'($urandom_range(0, 1));
      br = $urandom_range(0, 3) == 0;
      irq = $urandom_range(0, 2) == 0;
      ie = $urandom_range(0, 3) != 0;
      eret = $urandom_range(0, 7) == 0;
      halt = $urandom_range(0, 59) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
